// File: rtl/gcd_engine.sv
// Single-shot GCD engine (repeated subtraction) with start / result valid-ready handshakes.
// Define GCD_CYCLE_COUNT_EN to add the saturating iter_count output.
module gcd_engine #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] iter_count
`endif
);

  if (WIDTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("gcd_engine: WIDTH must be >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

`ifdef GCD_CYCLE_COUNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      opa        <= '0;
      opb        <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      iter_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa        <= a_in;
            opb        <= b_in;
            state      <= CALC;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
            iter_count <= '0;
`endif
          end
        end
        CALC: begin
          // A zero operand or equal operands end the run; otherwise shrink the larger one.
          if (opa == '0 || opb == '0 || opa == opb) begin
            result    <= (opa == '0) ? opb : opa;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (opa > opb) begin
            opa        <= opa - opb;
`ifdef GCD_CYCLE_COUNT_EN
            iter_count <= sat_inc(iter_count);
`endif
          end else begin
            opb        <= opb - opa;
`ifdef GCD_CYCLE_COUNT_EN
            iter_count <= sat_inc(iter_count);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
